// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the 32-bit ALU.
//   DATA_W / SHAMT_W : operand and shift-distance widths (only 32/5 supported)
//   OP_*             : 5-bit opcode encodings (OP_SRL/OP_XOR are used only
//                      when ALU_EXT_OPS_EN is defined)
package alu_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD = 5'b00000;
  localparam opcode_t OP_SUB = 5'b00001;
  localparam opcode_t OP_AND = 5'b00010;
  localparam opcode_t OP_OR  = 5'b00011;
  localparam opcode_t OP_SLL = 5'b00100;
  localparam opcode_t OP_SRA = 5'b00101;
  localparam opcode_t OP_SRL = 5'b00110;
  localparam opcode_t OP_XOR = 5'b00111;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control/result bundle between decode/execute and the ALU.
//   master : drives operands, opcode, shift amount; receives result and flags
//   slave  : the ALU side
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0]  data_operandA;
  logic [DATA_W-1:0]  data_operandB;
  opcode_t            ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [DATA_W-1:0]  data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;

  modport master (
    output data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    input  data_result, isNotEqual, isLessThan, overflow
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    output data_result, isNotEqual, isLessThan, overflow
  );
endinterface

// File: rtl/alu_adder32.sv
// alu_adder32: combinational DATA_W-bit adder with carry-in.
//   a, b, cin : addends (pass ~B with cin=1 to subtract)
//   sum       : a + b + cin, carry-out discarded
//   ovf       : signed overflow of the addition as seen by the operands given
module alu_adder32
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);
  assign sum = a + b + {{(DATA_W-1){1'b0}}, cin};
  // Same-sign addends producing an opposite-sign sum.
  assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
endmodule

// File: rtl/alu.sv
// alu: 32-bit integer ALU, all outputs registered (one clock latency).
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : operands A/B, opcode, shift amount in;
//                    data_result, isNotEqual, isLessThan, overflow out
// Optional: define ALU_EXT_OPS_EN to add SRL (00110) and XOR (00111).
module alu
  import alu_pkg::*;
(
  input logic  clock,
  input logic  reset_n,
  alu_if.slave bus
);
  logic [DATA_W-1:0]  a, b, sum, diff, sll_v, sra_v, res_d;
  logic [SHAMT_W-1:0] sh;
  logic               add_ovf, sub_ovf, ovf_d, ne_d, lt_d;
  logic               is_add, is_sub, is_and, is_or, is_sll, is_sra;

  assign a  = bus.data_operandA;
  assign b  = bus.data_operandB;
  assign sh = bus.ctrl_shiftamt;

  alu_adder32 u_add (.a(a), .b(b),  .cin(1'b0), .sum(sum),  .ovf(add_ovf));
  // A - B as A + ~B + 1; shared by SUB and the compare flags.
  alu_adder32 u_sub (.a(a), .b(~b), .cin(1'b1), .sum(diff), .ovf(sub_ovf));

  assign sll_v = a << sh;
  assign sra_v = $unsigned($signed(a) >>> sh);

  // Equality decodes feed an AND-OR mux so an unknown opcode propagates X
  // instead of silently falling into a default branch.
  assign is_add = (bus.ctrl_ALUopcode == OP_ADD);
  assign is_sub = (bus.ctrl_ALUopcode == OP_SUB);
  assign is_and = (bus.ctrl_ALUopcode == OP_AND);
  assign is_or  = (bus.ctrl_ALUopcode == OP_OR);
  assign is_sll = (bus.ctrl_ALUopcode == OP_SLL);
  assign is_sra = (bus.ctrl_ALUopcode == OP_SRA);

`ifdef ALU_EXT_OPS_EN
  logic is_srl, is_xor;
  assign is_srl = (bus.ctrl_ALUopcode == OP_SRL);
  assign is_xor = (bus.ctrl_ALUopcode == OP_XOR);
  assign res_d  = ({DATA_W{is_add}} & sum)     | ({DATA_W{is_sub}} & diff)
                | ({DATA_W{is_and}} & (a & b)) | ({DATA_W{is_or}}  & (a | b))
                | ({DATA_W{is_sll}} & sll_v)   | ({DATA_W{is_sra}} & sra_v)
                | ({DATA_W{is_srl}} & (a >> sh))
                | ({DATA_W{is_xor}} & (a ^ b));
`else
  assign res_d  = ({DATA_W{is_add}} & sum)     | ({DATA_W{is_sub}} & diff)
                | ({DATA_W{is_and}} & (a & b)) | ({DATA_W{is_or}}  & (a | b))
                | ({DATA_W{is_sll}} & sll_v)   | ({DATA_W{is_sra}} & sra_v);
`endif

  assign ovf_d = (is_add & add_ovf) | (is_sub & sub_ovf);
  assign ne_d  = |diff;
  // Sign of the difference corrected for wraparound.
  assign lt_d  = diff[DATA_W-1] ^ sub_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_result <= '0;
      bus.isNotEqual  <= 1'b0;
      bus.isLessThan  <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.data_result <= res_d;
      bus.isNotEqual  <= ne_d;
      bus.isLessThan  <= lt_d;
      bus.overflow    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  alu_if bus();
  alu dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  // Reference: {overflow, isLessThan, isNotEqual, result} from integer math.
  function automatic logic [34:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint s  = 0;
    logic [31:0] res = 32'h0;
    logic ovf = 1'b0;
    case (op)
      5'd0: begin res = a + b; s = sa + sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd1: begin res = a - b; s = sa - sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd2: res = a & b;
      5'd3: res = a | b;
      5'd4: res = a << sh;
      5'd5: res = 32'(sa >>> sh);
`ifdef ALU_EXT_OPS_EN
      5'd6: res = a >> sh;
      5'd7: res = a ^ b;
`endif
      default: res = 32'h0;
    endcase
    return {ovf, (sa < sb), (a != b), res};
  endfunction

  // Drive inputs just after an edge; outputs are sampled one clock later.
  task automatic apply(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bus.ctrl_ALUopcode = op;
    bus.data_operandA  = a;
    bus.data_operandB  = b;
    bus.ctrl_shiftamt  = sh;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ctrl_ALUopcode = OP_ADD;
    bus.data_operandA  = 32'hFFFF_FFFF;
    bus.data_operandB  = 32'h1234_5678;
    bus.ctrl_shiftamt  = 5'd0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus.overflow, bus.isLessThan, bus.isNotEqual, bus.data_result} !== 35'h0) begin
      errors++;
      $display("FAIL reset: got res=%h ne=%b lt=%b ovf=%b, want all 0",
               bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_logic();
    logic [4:0]  op [5] = '{OP_OR, OP_OR, OP_OR, OP_AND, OP_AND};
    logic [31:0] a  [5] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b  [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    logic [31:0] ex [5] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      apply(op[i], a[i], b[i], 5'd0);
      checks++;
      if (bus.data_result !== ex[i]) begin
        errors++;
        $display("FAIL logic[%0d]: got %h want %h", i, bus.data_result, ex[i]);
      end
    end
  endtask

  task automatic test_add_walk();
    for (int i = 0; i <= 30; i++) begin
      logic [31:0] v  = 32'h1 << i;
      logic [31:0] ex = 32'h1 << (i + 1);
      apply(OP_ADD, v, v, 5'd0);
      checks++;
      if (bus.data_result !== ex || bus.overflow !== (i == 30)) begin
        errors++;
        $display("FAIL add_walk[%0d]: got %h ovf=%b want %h ovf=%b",
                 i, bus.data_result, bus.overflow, ex, (i == 30));
      end
    end
    apply(OP_ADD, 32'h0, 32'h0, 5'd0);
    checks++;
    if (bus.data_result !== 32'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_zero: got %h ovf=%b want 0 ovf=0", bus.data_result, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    logic [4:0]  op [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [31:0] a  [4] = '{32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000};
    logic [31:0] b  [4] = '{32'h80000000, 32'h40000000, 32'h80000000, 32'h0F000000};
    logic        ex [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(op[i], a[i], b[i], 5'd0);
      checks++;
      if (bus.overflow !== ex[i]) begin
        errors++;
        $display("FAIL overflow[%0d]: got %b want %b", i, bus.overflow, ex[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [31:0] a  [3] = '{32'h0, 32'h0FFFFFFF, 32'h80000001};
    logic [31:0] b  [3] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic        ne [3] = '{1'b0, 1'b1, 1'b1};
    logic        lt [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply(OP_AND, a[i], b[i], 5'd0);
      checks++;
      if (bus.isNotEqual !== ne[i] || bus.isLessThan !== lt[i]) begin
        errors++;
        $display("FAIL compare[%0d]: got ne=%b lt=%b want ne=%b lt=%b",
                 i, bus.isNotEqual, bus.isLessThan, ne[i], lt[i]);
      end
    end
  endtask

  task automatic test_shift();
    int          sll_sh [10] = '{0, 1, 2, 4, 8, 16, 3, 6, 12, 24};
    int          sra_sh [7]  = '{1, 2, 4, 8, 16, 1, 16};
    logic [31:0] sra_a  [7]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                 32'h80000000, 32'h70000000, 32'h70000000};
    logic [31:0] sra_ex [7]  = '{32'hC0000000, 32'hE0000000, 32'hF8000000, 32'hFF800000,
                                 32'hFFFF8000, 32'h38000000, 32'h00007000};
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ex = 32'h1 << sll_sh[i];
      apply(OP_SLL, 32'h1, 32'hDEADBEEF, 5'(sll_sh[i]));
      checks++;
      if (bus.data_result !== ex) begin
        errors++;
        $display("FAIL sll[%0d]: got %h want %h", sll_sh[i], bus.data_result, ex);
      end
    end
    for (int i = 0; i < 7; i++) begin
      apply(OP_SRA, sra_a[i], 32'hFFFFFFFF, 5'(sra_sh[i]));
      checks++;
      if (bus.data_result !== sra_ex[i]) begin
        errors++;
        $display("FAIL sra[%0d]: got %h want %h", i, bus.data_result, sra_ex[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(OP_OR, 32'hFFFFFFFF, 32'h1, 5'd0);
    checks++;
    if (bus.data_result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL pre_async: got %h want ffffffff", bus.data_result);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.overflow, bus.isLessThan, bus.isNotEqual, bus.data_result} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset: got res=%h ne=%b lt=%b ovf=%b, want all 0",
               bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow);
    end
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_unused_op();
    apply(5'b01000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    checks++;
    if (bus.data_result !== 32'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL unused_op: got %h ovf=%b want 0 ovf=0", bus.data_result, bus.overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op = 5'($urandom_range(0, 9));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      logic [4:0]  sh = 5'($urandom_range(0, 31));
      logic [34:0] ex = model(op, a, b, sh);
      apply(op, a, b, sh);
      checks++;
      if ({bus.overflow, bus.isLessThan, bus.isNotEqual, bus.data_result} !== ex) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h sh=%0d: got ovf=%b lt=%b ne=%b res=%h want ovf=%b lt=%b ne=%b res=%h",
                 i, op, a, b, sh, bus.overflow, bus.isLessThan, bus.isNotEqual,
                 bus.data_result, ex[34], ex[33], ex[32], ex[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Sequence of different ops every cycle; each result must track its own inputs.
    for (int i = 0; i < 16; i++) begin
      logic [4:0]  op = 5'(i % 6);
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom;
      logic [4:0]  sh = 5'(i);
      logic [34:0] ex = model(op, a, b, sh);
      apply(op, a, b, sh);
      checks++;
      if ({bus.overflow, bus.isLessThan, bus.isNotEqual, bus.data_result} !== ex) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d: got res=%h want %h", i, op, bus.data_result, ex[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_add_walk();
    test_overflow();
    test_compare();
    test_shift();
    test_async_reset();
    test_unused_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the non-pipelined processor datapath, driven by the decode/execute stage.
- Performs ADD, SUB, AND, OR, SLL and SRA selected by a 5-bit opcode.
- Also produces signed compare flags and a signed overflow flag.
- All outputs are registered: one clock of latency from operand/control change to result.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is supported and verified; the shift-amount width is fixed at 5.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- data_operandA  input  32  operand A; also the shift source
- data_operandB  input  32  operand B
- ctrl_ALUopcode  input  5  operation select
- ctrl_shiftamt  input  5  shift distance, 0..31
- data_result  output  32  registered result
- isNotEqual  output  1  registered, A != B
- isLessThan  output  1  registered, signed A < B
- overflow  output  1  registered, signed overflow of ADD/SUB

Behaviour:
- Reset: reset_n low clears data_result, isNotEqual, isLessThan and overflow to 0 immediately (asynchronous). Release is synchronous to the next clock edge.
- Timing: inputs are sampled on every rising clock edge; outputs reflect those inputs until the next edge. There is no handshake or enable, and a new operation is accepted every cycle.
- Opcode map:
  - 00000 ADD: result = A + B, mod 2^32.
  - 00001 SUB: result = A - B, mod 2^32 (computed as A + ~B + 1).
  - 00010 AND: result = A & B.
  - 00011 OR: result = A | B.
  - 00100 SLL: result = A << shiftamt, zero fill.
  - 00101 SRA: result = A >>> shiftamt, sign fill from A[31]. Operand B is ignored for both shifts.
  - Any other opcode: result = 0, overflow = 0.
- Overflow flag:
  - ADD: 1 when A[31] == B[31] and sum[31] != A[31].
  - SUB: 1 when A[31] != B[31] and diff[31] != A[31].
  - All other opcodes: 0.
- Compare flags: always computed from D = A - B, independent of the opcode.
  - isNotEqual = (D != 0).
  - isLessThan = D[31] XOR subOverflow. This must be correct across overflow, e.g. 0x80000001 vs 0x7FFFFFFF gives 1.
- Carry-out is discarded; there is no carry/borrow output.
- Shift by 0 returns A unchanged.
- X on any input must not be masked; it may propagate to the outputs.

Optional Feature:
- Macro: ALU_EXT_OPS_EN.
- Defined: two extra opcodes.
  - 00110 SRL: logical right shift of A by shiftamt, zero fill.
  - 00111 XOR: A ^ B.
  - Overflow is 0 for both.
- Undefined: 00110 and 00111 fall into the "other opcode" rule (result 0).

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA, OP_SRL, OP_XOR.
  - DATA_W and SHAMT_W constants.
- One sub-module, alu_adder32: a 32-bit adder with carry-in that outputs sum and signed overflow, used for ADD and for SUB/compare.
- The barrel shifter, logic ops and output registers stay in the top level.

Test Plan (each check sampled one full clock after applying inputs):
- Reset and logic ops: hold reset_n=0 -> all outputs 0. Release, then:
  - OR: 0|0 = 0; FFFFFFFF|0 = FFFFFFFF; 0|FFFFFFFF = FFFFFFFF.
  - AND: FFFFFFFF&0 = 0; FFFFFFFF&FFFFFFFF = FFFFFFFF.
- ADD walk: for i=0..30, A=B=1<<i -> result 1<<(i+1), overflow 0 for i<30. Also 0+0 -> 0, overflow 0.
- Overflow:
  - ADD 80000000+80000000 -> overflow 1.
  - ADD 40000000+40000000 -> overflow 1.
  - SUB 80000000-80000000 -> overflow 0.
  - SUB 80000000-0F000000 -> overflow 1.
- Compare:
  - 0 vs 0 -> isNotEqual 0, isLessThan 0.
  - 0FFFFFFF vs FFFFFFFF -> isLessThan 0.
  - 80000001 vs 7FFFFFFF -> isLessThan 1.
- Shifts:
  - SLL of A=1 with shiftamt 0,1,2,4,8,16,3,6,12,24 -> 1<<shiftamt.
  - SRA of 80000000 by 1,2,4,8,16 -> C0000000, E0000000, F8000000, FF800000, FFFF8000.
  - SRA of 70000000 by 1 and 16 -> 38000000 and 00007000.
- Async reset and unused opcode:
  - Assert reset_n mid-operation between clock edges -> outputs clear before the next edge.
  - Opcode 01000 with A=B=FFFFFFFF -> result 0, overflow 0.
